// File: rtl/uart_tx_pkg.sv
// UART shared definitions: FSM state encodings used by both uart_tx and uart_rx.
// Contents: uart_state_t (IDLE, START, DATA, PARITY, STOP) and counter width constants.
// No ports; imported with import uart_tx_pkg::*.
package uart_tx_pkg;

  // Width of the per-bit clock count and of the stop-phase counter (2 * 255 clocks).
  localparam int CNT_W  = 8;
  localparam int STOP_W = CNT_W + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// Signals: tx_valid / tx_data from the producer, tx_ready back from the transmitter.
// Modports: master = producer side, slave = transmitter side.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_baud_cnt.sv
// Loadable bit-period down-counter: bit_end pulses in the clock where the count is 1.
// Ports: clk, rst (sync, active low), load, len[7:0] in; bit_end out (combinational from count).
// Reloads from len on load or on bit_end, so a stream of bits needs no extra control.
module uart_baud_cnt
  import uart_tx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             bit_end
);

  logic [CNT_W-1:0] cnt;

  assign bit_end = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load || bit_end) begin
      cnt <= len;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, idle-high LSB-first frame on serial_out.
// Ports: clk, rst (sync, active low), count[7:0] clocks per bit; tx (slave: valid/data/ready);
//        serial_out, tx_active, tx_done registered outputs. tx_ready is combinational.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] count,
  uart_tx_if.slave         tx,
  output logic             serial_out,
  output logic             tx_active,
  output logic             tx_done
);

  uart_state_t          state, state_nxt;
  logic [DATA_BITS-1:0] sr, sr_nxt;
  logic [2:0]           bit_idx, bit_idx_nxt;
  logic [CNT_W-1:0]     bit_len, bit_len_nxt;
  logic [CNT_W-1:0]     load_len, baud_len;
  logic [STOP_W-1:0]    stop_cnt, stop_cnt_nxt, stop_total;
  logic                 par, par_nxt;
  logic                 serial_nxt, active_nxt, done_nxt;
  logic                 accept, last_stop, bit_end;

  // A zero count would stall the baud counter; treat it as one clock per bit.
  assign load_len   = (count == '0) ? CNT_W'(1) : count;
  assign last_stop  = (state == STOP) && (stop_cnt == STOP_W'(1));
  assign tx.tx_ready = rst && ((state == IDLE) || last_stop);
  assign accept     = tx.tx_ready && tx.tx_valid;
  // On acceptance the counter must start with the new length, not the stale one.
  assign baud_len   = accept ? load_len : bit_len;
  assign stop_total = (STOP_BITS == 2) ? {bit_len, 1'b0} : {1'b0, bit_len};

  uart_baud_cnt u_baud (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .len     (baud_len),
    .bit_end (bit_end)
  );

  always_comb begin
    state_nxt    = state;
    sr_nxt       = sr;
    bit_idx_nxt  = bit_idx;
    bit_len_nxt  = bit_len;
    stop_cnt_nxt = stop_cnt;
    par_nxt      = par;

    case (state)
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            if (PARITY_EN != 0) begin
              state_nxt = PARITY;
            end else begin
              state_nxt    = STOP;
              stop_cnt_nxt = stop_total;
            end
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            sr_nxt      = sr >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt    = STOP;
          stop_cnt_nxt = stop_total;
        end
      end
      STOP: begin
        // The whole stop phase is timed by its own counter so the final clock is known ahead.
        if (stop_cnt > STOP_W'(1)) begin
          stop_cnt_nxt = stop_cnt - STOP_W'(1);
        end else begin
          state_nxt = IDLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      state_nxt   = START;
      sr_nxt      = tx.tx_data;
      bit_len_nxt = load_len;
      par_nxt     = (PARITY_ODD != 0) ? ~^tx.tx_data : ^tx.tx_data;
    end

    case (state_nxt)
      START:   serial_nxt = 1'b0;
      DATA:    serial_nxt = sr_nxt[0];
      PARITY:  serial_nxt = par_nxt;
      default: serial_nxt = 1'b1;
    endcase

    active_nxt = (state_nxt != IDLE);
    // Registered tx_done must rise for the clock in which stop_cnt will read 1.
    done_nxt   = (state_nxt == STOP) && (stop_cnt_nxt == STOP_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      sr         <= '0;
      bit_idx    <= '0;
      bit_len    <= CNT_W'(1);
      stop_cnt   <= '0;
      par        <= 1'b0;
      serial_out <= 1'b1;
      tx_active  <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      sr         <= sr_nxt;
      bit_idx    <= bit_idx_nxt;
      bit_len    <= bit_len_nxt;
      stop_cnt   <= stop_cnt_nxt;
      par        <= par_nxt;
      serial_out <= serial_nxt;
      tx_active  <= active_nxt;
      tx_done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: three instances (plain 8N1, even parity + 2 stop, odd parity + 1 stop).
// Frames are checked clock by clock against hand-written bit patterns.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] count;

  int compared;
  int mismatched;

  logic so0, act0, done0;
  logic so1, act1, done1;
  logic so2, act2, done2;

  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(8)) if1 ();
  uart_tx_if #(.DATA_BITS(8)) if2 ();

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .count(count), .tx(if0),
    .serial_out(so0), .tx_active(act0), .tx_done(done0));

  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .count(count), .tx(if1),
    .serial_out(so1), .tx_active(act1), .tx_done(done1));

  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .count(count), .tx(if2),
    .serial_out(so2), .tx_active(act2), .tx_done(done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sel: instance; cnt: count presented at acceptance; len: resulting bit length;
  // n: frame bits; frame: transmitted order, first bit at frame[n-1].
  typedef struct {
    int         sel;
    logic [7:0] cnt;
    int         len;
    logic [7:0] dat;
    int         n;
    logic [11:0] frame;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic get_so(input int s);
    case (s)
      0:       return so0;
      1:       return so1;
      default: return so2;
    endcase
  endfunction

  function automatic logic get_act(input int s);
    case (s)
      0:       return act0;
      1:       return act1;
      default: return act2;
    endcase
  endfunction

  function automatic logic get_done(input int s);
    case (s)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic get_rdy(input int s);
    case (s)
      0:       return if0.tx_ready;
      1:       return if1.tx_ready;
      default: return if2.tx_ready;
    endcase
  endfunction

  task automatic set_valid(input int s, input logic v, input logic [7:0] d);
    case (s)
      0:       begin if0.tx_valid = v; if0.tx_data = d; end
      1:       begin if1.tx_valid = v; if1.tx_data = d; end
      default: begin if2.tx_valid = v; if2.tx_data = d; end
    endcase
  endtask

  // Called at the negedge inside the first start-bit clock; returns at the negedge after the frame.
  task automatic check_frame(input int s, input logic [11:0] frame, input int n, input int len);
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < len; k++) begin
        logic last;
        last = (b == n - 1) && (k == len - 1);
        check($sformatf("serial s%0d bit%0d clk%0d", s, b, k), get_so(s), frame[n-1-b]);
        check($sformatf("active s%0d bit%0d", s, b), get_act(s), 1'b1);
        check($sformatf("done s%0d bit%0d clk%0d", s, b, k), get_done(s), last);
        check($sformatf("ready s%0d bit%0d clk%0d", s, b, k), get_rdy(s), last);
        @(negedge clk);
      end
    end
  endtask

  task automatic check_idle(input int s);
    check($sformatf("idle serial s%0d", s), get_so(s), 1'b1);
    check($sformatf("idle active s%0d", s), get_act(s), 1'b0);
    check($sformatf("idle done s%0d", s), get_done(s), 1'b0);
    check($sformatf("idle ready s%0d", s), get_rdy(s), 1'b1);
  endtask

  // Present a byte and wait (bounded) for the accepting edge; returns at the next negedge.
  task automatic send(input int s, input logic [7:0] c, input logic [7:0] d);
    int w;
    @(negedge clk);
    count = c;
    set_valid(s, 1'b1, d);
    w = 0;
    while (!get_rdy(s) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("accept ready s%0d", s), get_rdy(s), 1'b1);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    vecs[0] = '{0, 8'd50, 50, 8'hAA, 10, 12'b00_0_01010101_1};
    vecs[1] = '{0, 8'd0,  1,  8'h55, 10, 12'b00_0_10101010_1};
    vecs[2] = '{0, 8'd1,  1,  8'h0F, 10, 12'b00_0_11110000_1};
    vecs[3] = '{0, 8'd3,  3,  8'h3C, 10, 12'b00_0_00111100_1};
    vecs[4] = '{1, 8'd50, 50, 8'h07, 12, 12'b0_11100000_1_11};
    vecs[5] = '{2, 8'd50, 50, 8'h07, 11, 12'b0_0_11100000_0_1};
    vecs[6] = '{1, 8'd2,  2,  8'h81, 12, 12'b0_10000001_0_11};
    vecs[7] = '{2, 8'd4,  4,  8'h00, 11, 12'b0_0_00000000_1_1};

    rst   = 1'b0;
    count = 8'd50;
    set_valid(0, 1'b1, 8'hFF);
    set_valid(1, 1'b0, 8'h00);
    set_valid(2, 1'b0, 8'h00);

    // Reset held with tx_valid high: nothing may start.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst serial", so0, 1'b1);
      check("rst ready", if0.tx_ready, 1'b0);
      check("rst active", act0, 1'b0);
      check("rst done", done0, 1'b0);
    end
    set_valid(0, 1'b0, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    check_idle(0);
    check_idle(1);
    check_idle(2);

    // Back-to-back: 0x55 then 0x0F with tx_valid held through the first tx_done.
    send(0, 8'd50, 8'h55);
    set_valid(0, 1'b1, 8'h0F);
    check_frame(0, 12'b00_0_10101010_1, 10, 50);
    set_valid(0, 1'b0, 8'hEE);
    check_frame(0, 12'b00_0_11110000_1, 10, 50);
    check_idle(0);

    // Reset during data bit 3 of 0xA5 (bit 3 is 0): line returns high, no tx_done.
    send(0, 8'd10, 8'hA5);
    set_valid(0, 1'b0, 8'h00);
    repeat (45) @(negedge clk);
    check("pre-reset data bit3", so0, 1'b0);
    check("pre-reset active", act0, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort serial", so0, 1'b1);
    check("abort active", act0, 1'b0);
    check("abort done", done0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("abort hold done", done0, 1'b0);
    end
    rst = 1'b1;
    repeat (120) begin
      @(negedge clk);
      check("post-abort done", done0, 1'b0);
      check("post-abort serial", so0, 1'b1);
    end

    // Table: each frame must keep the length latched at acceptance even though count changes.
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].sel, vecs[v].cnt, vecs[v].dat);
      set_valid(vecs[v].sel, 1'b0, 8'h5A);
      count = 8'd20;
      check_frame(vecs[v].sel, vecs[v].frame, vecs[v].n, vecs[v].len);
      check_idle(vecs[v].sel);
    end

    // Count changed to 20 during the last frame: a new frame now uses 20-clock bits.
    send(0, 8'd20, 8'hC3);
    set_valid(0, 1'b0, 8'h00);
    check_frame(0, 12'b00_0_11000011_1, 10, 20);
    check_idle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
